// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C sensor master.
// Holds the FSM state encoding, the transfer-direction constants that go
// into the R/W bit, and the ACK/NACK levels seen on SDA.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START     = 4'd1,
        ST_ADDR      = 4'd2,
        ST_ADDR_ACK  = 4'd3,
        ST_WDATA     = 4'd4,
        ST_WDATA_ACK = 4'd5,
        ST_RDATA     = 4'd6,
        ST_MNACK     = 4'd7,
        ST_STOP      = 4'd8,
        ST_DONE      = 4'd9
    } i2c_state_e;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-period timebase for the I2C master.
// A bit is four quarters q0..q3, each CLK_DIV system clocks long. The counter
// and phase sit at zero while run_i is low, so every transaction starts at q0.
// Optional feature macro: I2C_SCL_STRETCH_EN -- when defined, the counter
// holds during q2 while SCL is released by us but still reads low on the pad.
// Ports:
//   clock, rst      system clock, async active-high reset
//   run_i           timer enable (master is on the bus)
//   scl_oe_i        our SCL pull-down enable
//   scl_in_i        SCL pad sense
//   phase_o         current quarter (0..3)
//   quarter_end_o   last clock of the current quarter
//   bit_end_o       last clock of q3, i.e. end of a bit
module i2c_bit_timer #(
    parameter int CLK_DIV = 4,
    parameter int DIV_W   = 8
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       run_i,
    input  logic       scl_oe_i,
    input  logic       scl_in_i,
    output logic [1:0] phase_o,
    output logic       quarter_end_o,
    output logic       bit_end_o
);

    localparam logic [DIV_W-1:0] TC = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic             hold;

`ifdef I2C_SCL_STRETCH_EN
    // A slave is stretching: we let SCL go but the wire stays low.
    assign hold = (phase_q == 2'd2) && !scl_oe_i && !scl_in_i;
`else
    logic unused_pads;
    assign unused_pads = scl_oe_i ^ scl_in_i;
    assign hold        = 1'b0;
`endif

    assign quarter_end_o = run_i && !hold && (cnt_q == TC);
    assign bit_end_o     = quarter_end_o && (phase_q == 2'd3);
    assign phase_o       = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!run_i) begin
            cnt_d   = '0;
            phase_d = 2'd0;
        end else if (quarter_end_o) begin
            cnt_d   = '0;
            phase_d = phase_q + 2'd1;
        end else if (!hold) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 2'd0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/i2c_sensor_master.sv
// Single-byte I2C bus master for sensor access.
// One transaction per accepted start: write = addr+W then one control byte,
// read = addr+R then one data byte answered with a master NACK.
// Optional feature macro: I2C_SCL_STRETCH_EN (slave clock stretching, handled
// inside i2c_bit_timer).
// Ports:
//   clock, rst        system clock, async active-high reset
//   sensorAddr_I2C    7-bit slave address (sampled at accept)
//   writeVal_I2C      byte to write (sampled at accept)
//   mode_I2C          0 = write, 1 = read (sampled at accept)
//   start_I2C         request, looked at only in IDLE
//   readVal_I2C       last byte read
//   dataRdy_I2C       one-cycle completion strobe
//   busy              transaction in progress
//   ack_err           slave NACKed address or write data this transaction
//   scl_oe, sda_oe    open-drain pull-down enables
//   scl_in, sda_in    pad sense
//
// state        | meaning
// IDLE         | lines released, waiting for start
// START        | START condition (SDA falls while SCL high)
// ADDR         | shifting {addr, R/W}
// ADDR_ACK     | slave acknowledges address
// WDATA        | shifting write byte
// WDATA_ACK    | slave acknowledges write byte
// RDATA        | receiving read byte
// MNACK        | master NACK ends the read
// STOP         | STOP condition (SDA rises while SCL high)
// DONE         | one-cycle completion strobe
module i2c_sensor_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DIV_W   = 8
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [6:0] sensorAddr_I2C,
    input  logic [7:0] writeVal_I2C,
    input  logic       mode_I2C,
    input  logic       start_I2C,
    output logic [7:0] readVal_I2C,
    output logic       dataRdy_I2C,
    output logic       busy,
    output logic       ack_err,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);

    i2c_state_e state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] data_q, data_d;
    logic       mode_q, mode_d;
    logic       ack_err_q, ack_err_d;
    logic [7:0] rdval_q, rdval_d;

    logic [1:0] phase;
    logic       quarter_end;
    logic       bit_end;
    logic       sample_en;
    logic       run;
    logic       scl_low;

    assign run       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign sample_en = quarter_end && (phase == 2'd2);
    assign scl_low   = (phase == 2'd0) || (phase == 2'd1);

    i2c_bit_timer #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_bit_timer (
        .clock         (clock),
        .rst           (rst),
        .run_i         (run),
        .scl_oe_i      (scl_oe),
        .scl_in_i      (scl_in),
        .phase_o       (phase),
        .quarter_end_o (quarter_end),
        .bit_end_o     (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        sh_d      = sh_q;
        data_d    = data_q;
        mode_d    = mode_q;
        ack_err_d = ack_err_q;
        rdval_d   = rdval_q;
        case (state_q)
            ST_IDLE: begin
                if (start_I2C) begin
                    sh_d      = {sensorAddr_I2C, mode_I2C};
                    data_d    = writeVal_I2C;
                    mode_d    = mode_I2C;
                    ack_err_d = 1'b0;
                    bitcnt_d  = 3'd0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (bit_end) begin
                    sh_d     = {sh_q[6:0], 1'b0};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = ST_ADDR_ACK;
                end
            end
            ST_ADDR_ACK: begin
                if (sample_en && sda_in == NACK) ack_err_d = 1'b1;
                // ack_err_q was updated at the q2 sample, well before bit_end.
                if (bit_end) begin
                    if (ack_err_q) begin
                        state_d = ST_STOP;
                    end else if (mode_q == I2C_WRITE) begin
                        sh_d    = data_q;
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_RDATA;
                    end
                end
            end
            ST_WDATA: begin
                if (bit_end) begin
                    sh_d     = {sh_q[6:0], 1'b0};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = ST_WDATA_ACK;
                end
            end
            ST_WDATA_ACK: begin
                if (sample_en && sda_in != ACK) ack_err_d = 1'b1;
                if (bit_end) state_d = ST_STOP;
            end
            ST_RDATA: begin
                if (sample_en) sh_d = {sh_q[6:0], sda_in};
                if (bit_end) begin
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = ST_MNACK;
                end
            end
            ST_MNACK: begin
                if (bit_end) begin
                    rdval_d = sh_q;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line drive is decoded straight from state/phase so a reset releases
    // both lines immediately.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            ST_START: begin
                scl_oe = (phase == 2'd3);
                sda_oe = (phase == 2'd2) || (phase == 2'd3);
            end
            ST_ADDR, ST_WDATA: begin
                scl_oe = scl_low;
                sda_oe = ~sh_q[7];
            end
            ST_ADDR_ACK, ST_WDATA_ACK, ST_RDATA, ST_MNACK: begin
                scl_oe = scl_low;
            end
            ST_STOP: begin
                scl_oe = scl_low;
                sda_oe = (phase != 2'd3);
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

    // busy includes the accept cycle so that back-to-back requests leave it
    // low only for the DONE cycle.
    assign busy        = run || ((state_q == ST_IDLE) && start_I2C);
    assign dataRdy_I2C = (state_q == ST_DONE);
    assign ack_err     = ack_err_q;
    assign readVal_I2C = rdval_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bitcnt_q  <= 3'd0;
            sh_q      <= 8'd0;
            data_q    <= 8'd0;
            mode_q    <= 1'b0;
            ack_err_q <= 1'b0;
            rdval_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            mode_q    <= mode_d;
            ack_err_q <= ack_err_d;
            rdval_q   <= rdval_d;
        end
    end

endmodule

// File: tb/tb_i2c_sensor_master.sv
// Directed testbench for i2c_sensor_master with CLK_DIV=2.
// A small open-drain bus and slave model watch SCL/SDA, capture the bytes
// the master clocks out, and answer with ACKs and read data.
module tb_i2c_sensor_master;

    localparam int CLK_DIV = 2;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic [6:0] sensorAddr = 7'd0;
    logic [7:0] writeVal   = 8'd0;
    logic       mode       = 1'b0;
    logic       start      = 1'b0;
    logic [7:0] readVal;
    logic       dataRdy;
    logic       busy;
    logic       ack_err;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_bus;
    logic       sda_bus;

    logic       slave_sda   = 1'b1;
    logic       stretch_low = 1'b0;
    logic       slave_ack_en = 1'b1;
    logic [7:0] read_byte   = 8'h00;

    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       active   = 1'b0;
    int         rise_cnt = 0;
    int         stop_cnt = 0;
    logic [7:0] addr_cap = 8'h00;
    logic [7:0] data_cap = 8'h00;
    logic       bit9     = 1'b1;
    logic       bit18    = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign scl_bus = ~scl_oe & ~stretch_low;
    assign sda_bus = ~sda_oe & slave_sda;

    i2c_sensor_master #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (8)
    ) dut (
        .clock          (clock),
        .rst            (rst),
        .sensorAddr_I2C (sensorAddr),
        .writeVal_I2C   (writeVal),
        .mode_I2C       (mode),
        .start_I2C      (start),
        .readVal_I2C    (readVal),
        .dataRdy_I2C    (dataRdy),
        .busy           (busy),
        .ack_err        (ack_err),
        .scl_oe         (scl_oe),
        .sda_oe         (sda_oe),
        .scl_in         (scl_bus),
        .sda_in         (sda_bus)
    );

    // Slave / bus monitor, evaluated away from the DUT clock edge.
    always @(negedge clock) begin
        prev_scl <= scl_bus;
        prev_sda <= sda_bus;
        if (rst) begin
            active    <= 1'b0;
            slave_sda <= 1'b1;
        end else if (scl_bus && prev_scl && prev_sda && !sda_bus) begin
            active   <= 1'b1;
            rise_cnt <= 0;
        end else if (scl_bus && prev_scl && !prev_sda && sda_bus) begin
            active    <= 1'b0;
            stop_cnt  <= stop_cnt + 1;
            slave_sda <= 1'b1;
        end else if (active && scl_bus && !prev_scl) begin
            rise_cnt <= rise_cnt + 1;
            if (rise_cnt < 8)       addr_cap <= {addr_cap[6:0], sda_bus};
            else if (rise_cnt == 8) bit9     <= sda_bus;
            else if (rise_cnt < 17) data_cap <= {data_cap[6:0], sda_bus};
            else if (rise_cnt == 17) bit18   <= sda_bus;
        end else if (active && !scl_bus && prev_scl) begin
            slave_sda <= 1'b1;
            if (rise_cnt == 8 && slave_ack_en)
                slave_sda <= 1'b0;
            else if (rise_cnt >= 9 && rise_cnt <= 16 && addr_cap[0] && !bit9)
                slave_sda <= read_byte[16 - rise_cnt];
            else if (rise_cnt == 17 && !addr_cap[0] && slave_ack_en)
                slave_sda <= 1'b0;
        end
    end

    // Issue one request and return the number of cycles from the accept
    // cycle to the cycle showing dataRdy (-1 if it never came).
    task automatic run_txn(input logic [6:0] a, input logic [7:0] v,
                           input logic m, output int lat);
        @(negedge clock);
        sensorAddr = a;
        writeVal   = v;
        mode       = m;
        start      = 1'b1;
        lat        = -1;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (dataRdy) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL reset_scl_oe got %b exp 0", scl_oe); end
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b exp 0", sda_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (dataRdy !== 1'b0) begin errors++; $display("FAIL reset_dataRdy got %b exp 0", dataRdy); end
        checks++; if (readVal !== 8'h00) begin errors++; $display("FAIL reset_readVal got %h exp 00", readVal); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err got %b exp 0", ack_err); end
        @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_write();
        int lat;
        int stops0;
        slave_ack_en = 1'b1;
        stops0 = stop_cnt;
        run_txn(7'h48, 8'h03, 1'b0, lat);
        checks++; if (lat !== 161) begin errors++; $display("FAIL write_latency got %0d exp 161", lat); end
        checks++; if (addr_cap !== 8'h90) begin errors++; $display("FAIL write_addr_byte got %h exp 90", addr_cap); end
        checks++; if (data_cap !== 8'h03) begin errors++; $display("FAIL write_data_byte got %h exp 03", data_cap); end
        checks++; if (bit18 !== 1'b0) begin errors++; $display("FAIL write_data_ack got %b exp 0", bit18); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL write_ack_err got %b exp 0", ack_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_done got %b exp 0", busy); end
        checks++; if (readVal !== 8'h00) begin errors++; $display("FAIL write_readVal got %h exp 00", readVal); end
        checks++; if (rise_cnt !== 19) begin errors++; $display("FAIL write_scl_pulses got %0d exp 19", rise_cnt); end
        checks++; if (stop_cnt !== stops0 + 1) begin errors++; $display("FAIL write_stop got %0d exp %0d", stop_cnt, stops0 + 1); end
        @(negedge clock);
        checks++; if (dataRdy !== 1'b0) begin errors++; $display("FAIL write_strobe_width got %b exp 0", dataRdy); end
        checks++; if ({scl_oe, sda_oe} !== 2'b00) begin errors++; $display("FAIL write_lines_idle got %b exp 00", {scl_oe, sda_oe}); end
    endtask

    task automatic test_read();
        int lat;
        slave_ack_en = 1'b1;
        read_byte    = 8'hA5;
        run_txn(7'h48, 8'hFF, 1'b1, lat);
        checks++; if (lat !== 161) begin errors++; $display("FAIL read_latency got %0d exp 161", lat); end
        checks++; if (addr_cap !== 8'h91) begin errors++; $display("FAIL read_addr_byte got %h exp 91", addr_cap); end
        checks++; if (readVal !== 8'hA5) begin errors++; $display("FAIL read_value got %h exp a5", readVal); end
        checks++; if (bit18 !== 1'b1) begin errors++; $display("FAIL read_master_nack got %b exp 1", bit18); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL read_ack_err got %b exp 0", ack_err); end
        @(negedge clock);
    endtask

    task automatic test_addr_nack();
        int lat;
        int stops0;
        slave_ack_en = 1'b0;
        stops0 = stop_cnt;
        run_txn(7'h21, 8'h00, 1'b1, lat);
        checks++; if (lat !== 89) begin errors++; $display("FAIL nack_latency got %0d exp 89", lat); end
        checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL nack_ack_err got %b exp 1", ack_err); end
        checks++; if (rise_cnt !== 10) begin errors++; $display("FAIL nack_scl_pulses got %0d exp 10", rise_cnt); end
        checks++; if (stop_cnt !== stops0 + 1) begin errors++; $display("FAIL nack_stop got %0d exp %0d", stop_cnt, stops0 + 1); end
        checks++; if (readVal !== 8'hA5) begin errors++; $display("FAIL nack_readVal got %h exp a5", readVal); end
        @(negedge clock);
        slave_ack_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int n;
        slave_ack_en = 1'b1;
        @(negedge clock);
        sensorAddr = 7'h48;
        writeVal   = 8'h5A;
        mode       = 1'b0;
        start      = 1'b1;
        n = -1;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clock);
            if (dataRdy) begin n = i; break; end
        end
        checks++; if (n !== 161) begin errors++; $display("FAIL b2b_first_latency got %0d exp 161", n); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL b2b_ack_err_cleared got %b exp 0", ack_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_done got %b exp 0", busy); end
        @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_accept got %b exp 1", busy); end
        @(negedge clock);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_start got %b exp 1", busy); end
        n = -1;
        for (int i = 3; i <= 3000; i++) begin
            @(negedge clock);
            if (dataRdy) begin n = i; break; end
        end
        checks++; if (n !== 162) begin errors++; $display("FAIL b2b_second_done got %0d exp 162", n); end
        checks++; if (data_cap !== 8'h5A) begin errors++; $display("FAIL b2b_data_byte got %h exp 5a", data_cap); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int lat;
        bit hit;
        slave_ack_en = 1'b1;
        read_byte    = 8'hC3;
        @(negedge clock);
        sensorAddr = 7'h48;
        mode       = 1'b1;
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (rise_cnt == 13) begin hit = 1'b1; break; end
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rstmid_reach_rdata got %b exp 1", hit); end
        rst = 1'b1;
        #1;
        checks++; if ({scl_oe, sda_oe} !== 2'b00) begin errors++; $display("FAIL rstmid_lines got %b exp 00", {scl_oe, sda_oe}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        checks++; if (readVal !== 8'h00) begin errors++; $display("FAIL rstmid_readVal got %h exp 00", readVal); end
        @(negedge clock);
        @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        read_byte = 8'h3C;
        run_txn(7'h48, 8'h00, 1'b1, lat);
        checks++; if (lat !== 161) begin errors++; $display("FAIL rstmid_after_latency got %0d exp 161", lat); end
        checks++; if (readVal !== 8'h3C) begin errors++; $display("FAIL rstmid_after_value got %h exp 3c", readVal); end
        @(negedge clock);
    endtask

`ifdef I2C_SCL_STRETCH_EN
    task automatic test_stretch();
        int lat;
        bit hit;
        slave_ack_en = 1'b1;
        hit = 1'b0;
        fork
            run_txn(7'h48, 8'hE7, 1'b0, lat);
            begin
                logic last_oe;
                last_oe = 1'b0;
                for (int i = 0; i < 3000; i++) begin
                    @(posedge clock);
                    #1;
                    if (last_oe && !scl_oe && rise_cnt == 8) begin
                        hit = 1'b1;
                        break;
                    end
                    last_oe = scl_oe;
                end
                if (hit) begin
                    stretch_low = 1'b1;
                    repeat (10) @(posedge clock);
                    #1;
                    stretch_low = 1'b0;
                end
            end
        join
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL stretch_found_ack got %b exp 1", hit); end
        checks++; if (lat !== 171) begin errors++; $display("FAIL stretch_latency got %0d exp 171", lat); end
        checks++; if (data_cap !== 8'hE7) begin errors++; $display("FAIL stretch_data_byte got %h exp e7", data_cap); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL stretch_ack_err got %b exp 0", ack_err); end
        @(negedge clock);
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_back_to_back();
        test_reset_mid();
`ifdef I2C_SCL_STRETCH_EN
        test_stretch();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
